ex_stage: RTL and testbench



---
 rtl/ex_pkg.sv | 76 +++++++
 rtl/ex_stage_mdu.sv | 122 ++++++++++++
 rtl/ex_stage.sv | 173 +++++++++++++++++
 tb/tb_ex_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: instruction ids, ALU ops,
// MDU states and the EX/MEM pipeline register payload.
package ex_pkg;

  localparam int unsigned WIDTH_INSTR = 6;
  localparam int unsigned WIDTH_T     = 2;

  localparam logic [WIDTH_INSTR-1:0] ID_NOP   = 6'd0;
  localparam logic [WIDTH_INSTR-1:0] ID_ADDU  = 6'd1;
  localparam logic [WIDTH_INSTR-1:0] ID_SUBU  = 6'd2;
  localparam logic [WIDTH_INSTR-1:0] ID_AND   = 6'd3;
  localparam logic [WIDTH_INSTR-1:0] ID_OR    = 6'd4;
  localparam logic [WIDTH_INSTR-1:0] ID_XOR   = 6'd5;
  localparam logic [WIDTH_INSTR-1:0] ID_NOR   = 6'd6;
  localparam logic [WIDTH_INSTR-1:0] ID_SLT   = 6'd7;
  localparam logic [WIDTH_INSTR-1:0] ID_SLTU  = 6'd8;
  localparam logic [WIDTH_INSTR-1:0] ID_SLL   = 6'd9;
  localparam logic [WIDTH_INSTR-1:0] ID_SRL   = 6'd10;
  localparam logic [WIDTH_INSTR-1:0] ID_SRA   = 6'd11;
  localparam logic [WIDTH_INSTR-1:0] ID_SLLV  = 6'd12;
  localparam logic [WIDTH_INSTR-1:0] ID_SRLV  = 6'd13;
  localparam logic [WIDTH_INSTR-1:0] ID_SRAV  = 6'd14;
  localparam logic [WIDTH_INSTR-1:0] ID_ADDIU = 6'd15;
  localparam logic [WIDTH_INSTR-1:0] ID_ANDI  = 6'd16;
  localparam logic [WIDTH_INSTR-1:0] ID_ORI   = 6'd17;
  localparam logic [WIDTH_INSTR-1:0] ID_XORI  = 6'd18;
  localparam logic [WIDTH_INSTR-1:0] ID_SLTI  = 6'd19;
  localparam logic [WIDTH_INSTR-1:0] ID_SLTIU = 6'd20;
  localparam logic [WIDTH_INSTR-1:0] ID_LUI   = 6'd21;
  localparam logic [WIDTH_INSTR-1:0] ID_LW    = 6'd22;
  localparam logic [WIDTH_INSTR-1:0] ID_LH    = 6'd23;
  localparam logic [WIDTH_INSTR-1:0] ID_LHU   = 6'd24;
  localparam logic [WIDTH_INSTR-1:0] ID_LB    = 6'd25;
  localparam logic [WIDTH_INSTR-1:0] ID_LBU   = 6'd26;
  localparam logic [WIDTH_INSTR-1:0] ID_SW    = 6'd27;
  localparam logic [WIDTH_INSTR-1:0] ID_SH    = 6'd28;
  localparam logic [WIDTH_INSTR-1:0] ID_SB    = 6'd29;
  localparam logic [WIDTH_INSTR-1:0] ID_MULT  = 6'd30;
  localparam logic [WIDTH_INSTR-1:0] ID_MULTU = 6'd31;
  localparam logic [WIDTH_INSTR-1:0] ID_DIV   = 6'd32;
  localparam logic [WIDTH_INSTR-1:0] ID_DIVU  = 6'd33;
  localparam logic [WIDTH_INSTR-1:0] ID_MFHI  = 6'd34;
  localparam logic [WIDTH_INSTR-1:0] ID_MFLO  = 6'd35;
  localparam logic [WIDTH_INSTR-1:0] ID_MTHI  = 6'd36;
  localparam logic [WIDTH_INSTR-1:0] ID_MTLO  = 6'd37;
  localparam logic [WIDTH_INSTR-1:0] ID_JAL   = 6'd38;
  localparam logic [WIDTH_INSTR-1:0] ID_BEQ   = 6'd39;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;

  typedef struct packed {
    logic [WIDTH_INSTR-1:0] instr;
    logic [31:0]            pc;
    logic [31:0]            alu_out;
    logic [31:0]            data_rt;
    logic [4:0]             addr_rt;
    logic [4:0]             addr_rd;
    logic [4:0]             reg_write_addr;
    logic [31:0]            reg_write_data;
    logic [WIDTH_T-1:0]     tnew;
  } exmem_t;

  function automatic logic is_mult(input logic [WIDTH_INSTR-1:0] id);
    return (id == ID_MULT) || (id == ID_MULTU);
  endfunction

  function automatic logic is_mdu_start(input logic [WIDTH_INSTR-1:0] id);
    return is_mult(id) || (id == ID_DIV) || (id == ID_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO; operands are latched at start
// and the result is committed on the last busy cycle.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [WIDTH_INSTR-1:0] instr,
  input  logic [31:0]            rs,
  input  logic [31:0]            rt,
  output logic [31:0]            hi,
  output logic [31:0]            lo,
  output logic                   busy
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH_INSTR-1:0] op_q, op_d;
  logic [31:0]            a_q, a_d, b_q, b_d;
  logic [31:0]            hi_q, hi_d, lo_q, lo_d;
  logic                   res_wr_c;
  logic [31:0]            res_hi_c, res_lo_c;

  // Result of the latched operation; divide by zero leaves HI/LO untouched
  always_comb begin
    res_wr_c = 1'b0;
    res_hi_c = hi_q;
    res_lo_c = lo_q;
    unique case (op_q)
      ID_MULT: begin
        res_wr_c = 1'b1;
        {res_hi_c, res_lo_c} = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      end
      ID_MULTU: begin
        res_wr_c = 1'b1;
        {res_hi_c, res_lo_c} = {32'd0, a_q} * {32'd0, b_q};
      end
      ID_DIV: begin
        if (b_q != 32'd0) begin
          res_wr_c = 1'b1;
          res_lo_c = $signed(a_q) / $signed(b_q);
          res_hi_c = $signed(a_q) % $signed(b_q);
        end
      end
      ID_DIVU: begin
        if (b_q != 32'd0) begin
          res_wr_c = 1'b1;
          res_lo_c = a_q / b_q;
          res_hi_c = a_q % b_q;
        end
      end
      default: ;
    endcase
  end

  // Next state; completion is evaluated after mt* so it wins on the same edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (!stall && instr == ID_MTHI) hi_d = rs;
    if (!stall && instr == ID_MTLO) lo_d = rs;
    unique case (state_q)
      MDU_IDLE: begin
        if (!stall && is_mdu_start(instr)) begin
          state_d = MDU_BUSY;
          cnt_d   = is_mult(instr) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          op_d    = instr;
          a_d     = rs;
          b_d     = rt;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MDU_IDLE;
          if (res_wr_c) begin
            hi_d = res_hi_c;
            lo_d = res_lo_c;
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == MDU_BUSY);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: MEM/WB forwarding, ALU, optional MDU and the EX/MEM register.
// Define EX_MDU_EN to build the multiply/divide unit with HI/LO.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   clr,
  input  logic [WIDTH_INSTR-1:0] instr_EX,
  input  logic [31:0]            PC_EX,
  input  logic [31:0]            dataRs_EX,
  input  logic [31:0]            dataRt_EX,
  input  logic [31:0]            imm_EX,
  input  logic [4:0]             addrRs_EX,
  input  logic [4:0]             addrRt_EX,
  input  logic [4:0]             addrRd_EX,
  input  logic [4:0]             regWriteAddr_EX,
  input  logic [31:0]            regWriteData_EX,
  input  logic [WIDTH_T-1:0]     Tnew_EX,
  input  logic [4:0]             regaddr_MEM,
  input  logic [4:0]             regaddr_WB,
  input  logic [31:0]            regdata_MEM,
  input  logic [31:0]            regdata_WB,
  input  logic                   regvalid_MEM,
  output logic [WIDTH_INSTR-1:0] instr_MEM,
  output logic [31:0]            PC_MEM,
  output logic [31:0]            aluOut_MEM,
  output logic [31:0]            dataRt_MEM,
  output logic [4:0]             addrRt_MEM,
  output logic [4:0]             addrRd_MEM,
  output logic [4:0]             regWriteAddr_MEM,
  output logic [31:0]            regWriteData_MEM,
  output logic [WIDTH_T-1:0]     Tnew_MEM,
  output logic                   mdu_busy
);

  logic [31:0] rs_val, rt_val, opb, alu_res, hi, lo;
  logic [4:0]  shamt;
  alu_op_e     alu_op;
  logic        use_imm, var_shift, alu_wr;
  exmem_t      exmem_d, exmem_q;

  // MEM beats WB only when its data is final; $0 is never forwarded
  always_comb begin
    rs_val = dataRs_EX;
    if (addrRs_EX != 5'd0 && addrRs_EX == regaddr_MEM && regvalid_MEM) rs_val = regdata_MEM;
    else if (addrRs_EX != 5'd0 && addrRs_EX == regaddr_WB)             rs_val = regdata_WB;
    rt_val = dataRt_EX;
    if (addrRt_EX != 5'd0 && addrRt_EX == regaddr_MEM && regvalid_MEM) rt_val = regdata_MEM;
    else if (addrRt_EX != 5'd0 && addrRt_EX == regaddr_WB)             rt_val = regdata_WB;
  end

  always_comb begin
    alu_op    = ALU_NONE;
    use_imm   = 1'b0;
    var_shift = 1'b0;
    alu_wr    = 1'b1;
    unique case (instr_EX)
      ID_ADDU:  alu_op = ALU_ADD;
      ID_SUBU:  alu_op = ALU_SUB;
      ID_AND:   alu_op = ALU_AND;
      ID_OR:    alu_op = ALU_OR;
      ID_XOR:   alu_op = ALU_XOR;
      ID_NOR:   alu_op = ALU_NOR;
      ID_SLT:   alu_op = ALU_SLT;
      ID_SLTU:  alu_op = ALU_SLTU;
      ID_SLL:   alu_op = ALU_SLL;
      ID_SRL:   alu_op = ALU_SRL;
      ID_SRA:   alu_op = ALU_SRA;
      ID_SLLV:  begin alu_op = ALU_SLL;  var_shift = 1'b1; end
      ID_SRLV:  begin alu_op = ALU_SRL;  var_shift = 1'b1; end
      ID_SRAV:  begin alu_op = ALU_SRA;  var_shift = 1'b1; end
      ID_ADDIU: begin alu_op = ALU_ADD;  use_imm = 1'b1; end
      ID_ANDI:  begin alu_op = ALU_AND;  use_imm = 1'b1; end
      ID_ORI:   begin alu_op = ALU_OR;   use_imm = 1'b1; end
      ID_XORI:  begin alu_op = ALU_XOR;  use_imm = 1'b1; end
      ID_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; end
      ID_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; end
      ID_LUI:   alu_op = ALU_LUI;
      ID_LW, ID_LH, ID_LHU, ID_LB, ID_LBU, ID_SW, ID_SH, ID_SB: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        alu_wr  = 1'b0;
      end
      default:  alu_wr = 1'b0;
    endcase
  end

  always_comb begin
    opb     = use_imm ? imm_EX : rt_val;
    shamt   = var_shift ? rs_val[4:0] : imm_EX[10:6];
    alu_res = '0;
    unique case (alu_op)
      ALU_ADD:  alu_res = rs_val + opb;
      ALU_SUB:  alu_res = rs_val - opb;
      ALU_AND:  alu_res = rs_val & opb;
      ALU_OR:   alu_res = rs_val | opb;
      ALU_XOR:  alu_res = rs_val ^ opb;
      ALU_NOR:  alu_res = ~(rs_val | opb);
      ALU_SLT:  alu_res = {31'd0, $signed(rs_val) < $signed(opb)};
      ALU_SLTU: alu_res = {31'd0, rs_val < opb};
      ALU_SLL:  alu_res = rt_val << shamt;
      ALU_SRL:  alu_res = rt_val >> shamt;
      ALU_SRA:  alu_res = $signed(rt_val) >>> shamt;
      ALU_LUI:  alu_res = {imm_EX[15:0], 16'd0};
      default:  alu_res = '0;
    endcase
  end

`ifdef EX_MDU_EN
  logic mdu_running;

  ex_stage_mdu #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .instr (instr_EX),
    .rs    (rs_val),
    .rt    (rt_val),
    .hi    (hi),
    .lo    (lo),
    .busy  (mdu_running)
  );

  assign mdu_busy = mdu_running || is_mdu_start(instr_EX);
`else
  logic unused_mdu_cfg;

  assign unused_mdu_cfg = ^{32'(MULT_CYCLES), 32'(DIV_CYCLES)};
  assign hi             = '0;
  assign lo             = '0;
  assign mdu_busy       = 1'b0;
`endif

  always_comb begin
    exmem_d.instr          = instr_EX;
    exmem_d.pc             = PC_EX;
    exmem_d.alu_out        = alu_res;
    exmem_d.data_rt        = rt_val;
    exmem_d.addr_rt        = addrRt_EX;
    exmem_d.addr_rd        = addrRd_EX;
    exmem_d.reg_write_addr = regWriteAddr_EX;
    exmem_d.tnew           = (Tnew_EX != '0) ? Tnew_EX - WIDTH_T'(1) : '0;
    if (alu_wr)                  exmem_d.reg_write_data = alu_res;
    else if (instr_EX == ID_MFHI) exmem_d.reg_write_data = hi;
    else if (instr_EX == ID_MFLO) exmem_d.reg_write_data = lo;
    else                          exmem_d.reg_write_data = regWriteData_EX;
  end

  // Bubble insertion overrides a hold
  always_ff @(posedge clk) begin
    if (reset || clr)  exmem_q <= '0;
    else if (!stall)   exmem_q <= exmem_d;
  end

  assign instr_MEM        = exmem_q.instr;
  assign PC_MEM           = exmem_q.pc;
  assign aluOut_MEM       = exmem_q.alu_out;
  assign dataRt_MEM       = exmem_q.data_rt;
  assign addrRt_MEM       = exmem_q.addr_rt;
  assign addrRd_MEM       = exmem_q.addr_rd;
  assign regWriteAddr_MEM = exmem_q.reg_write_addr;
  assign regWriteData_MEM = exmem_q.reg_write_data;
  assign Tnew_MEM         = exmem_q.tnew;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random traffic,
// compared against an arithmetic reference model of the stage and of HI/LO.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;
`ifdef EX_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset, stall, clr, regvalid_MEM;
  logic [WIDTH_INSTR-1:0] instr_EX, instr_MEM;
  logic [31:0]            PC_EX, dataRs_EX, dataRt_EX, imm_EX, regWriteData_EX;
  logic [4:0]             addrRs_EX, addrRt_EX, addrRd_EX, regWriteAddr_EX;
  logic [WIDTH_T-1:0]     Tnew_EX, Tnew_MEM;
  logic [4:0]             regaddr_MEM, regaddr_WB;
  logic [31:0]            regdata_MEM, regdata_WB;
  logic [31:0]            PC_MEM, aluOut_MEM, dataRt_MEM, regWriteData_MEM;
  logic [4:0]             addrRt_MEM, addrRd_MEM, regWriteAddr_MEM;
  logic                   mdu_busy;

  ex_stage #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .stall(stall), .clr(clr),
    .instr_EX(instr_EX), .PC_EX(PC_EX), .dataRs_EX(dataRs_EX), .dataRt_EX(dataRt_EX),
    .imm_EX(imm_EX), .addrRs_EX(addrRs_EX), .addrRt_EX(addrRt_EX), .addrRd_EX(addrRd_EX),
    .regWriteAddr_EX(regWriteAddr_EX), .regWriteData_EX(regWriteData_EX), .Tnew_EX(Tnew_EX),
    .regaddr_MEM(regaddr_MEM), .regaddr_WB(regaddr_WB), .regdata_MEM(regdata_MEM),
    .regdata_WB(regdata_WB), .regvalid_MEM(regvalid_MEM),
    .instr_MEM(instr_MEM), .PC_MEM(PC_MEM), .aluOut_MEM(aluOut_MEM), .dataRt_MEM(dataRt_MEM),
    .addrRt_MEM(addrRt_MEM), .addrRd_MEM(addrRd_MEM), .regWriteAddr_MEM(regWriteAddr_MEM),
    .regWriteData_MEM(regWriteData_MEM), .Tnew_MEM(Tnew_MEM), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit                     m_valid = 1'b0;
  logic [31:0]            m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit                     p_wr = 1'b0;
  int                     m_left = 0;
  logic [WIDTH_INSTR-1:0] e_instr;
  logic [31:0]            e_pc, e_alu, e_rt, e_wd;
  logic [4:0]             e_art, e_ard, e_wa;
  logic [WIDTH_T-1:0]     e_tnew;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0 && a == regaddr_MEM && regvalid_MEM) return regdata_MEM;
    if (a != 5'd0 && a == regaddr_WB) return regdata_WB;
    return d;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [WIDTH_INSTR-1:0] id,
                                          input logic [31:0] s, input logic [31:0] t,
                                          input logic [31:0] imm);
    int signed ss = s;
    int signed ts = t;
    int signed is = imm;
    case (id)
      ID_ADDU:  return s + t;
      ID_SUBU:  return s - t;
      ID_AND:   return s & t;
      ID_OR:    return s | t;
      ID_XOR:   return s ^ t;
      ID_NOR:   return ~(s | t);
      ID_SLT:   return (ss < ts) ? 32'd1 : 32'd0;
      ID_SLTU:  return (s < t) ? 32'd1 : 32'd0;
      ID_SLL:   return t << imm[10:6];
      ID_SRL:   return t >> imm[10:6];
      ID_SRA:   return 32'(ts >>> imm[10:6]);
      ID_SLLV:  return t << s[4:0];
      ID_SRLV:  return t >> s[4:0];
      ID_SRAV:  return 32'(ts >>> s[4:0]);
      ID_ANDI:  return s & imm;
      ID_ORI:   return s | imm;
      ID_XORI:  return s ^ imm;
      ID_SLTI:  return (ss < is) ? 32'd1 : 32'd0;
      ID_SLTIU: return (s < imm) ? 32'd1 : 32'd0;
      ID_LUI:   return imm << 16;
      ID_ADDIU, ID_LW, ID_LH, ID_LHU, ID_LB, ID_LBU, ID_SW, ID_SH, ID_SB: return s + imm;
      default:  return 32'd0;
    endcase
  endfunction

  // One clock: predict from current inputs, advance, compare registered outputs
  task automatic tick();
    logic [31:0] s, t, alu, wd;
    logic [63:0] p64;
    int          a, b, old_left;
    bit          start;
    #1;
    s     = fwd(addrRs_EX, dataRs_EX);
    t     = fwd(addrRt_EX, dataRt_EX);
    start = MDU_EN && (instr_EX inside {ID_MULT, ID_MULTU, ID_DIV, ID_DIVU});
    if (m_valid) check("mdu_busy", 64'(mdu_busy), 64'((m_left > 0) || start));
    alu = alu_ref(instr_EX, s, t, imm_EX);
    if (instr_EX inside {[ID_ADDU:ID_LUI]}) wd = alu;
    else if (instr_EX == ID_MFHI)           wd = m_hi;
    else if (instr_EX == ID_MFLO)           wd = m_lo;
    else                                    wd = regWriteData_EX;
    if (reset || clr) begin
      e_instr = '0; e_pc = '0; e_alu = '0; e_rt = '0; e_art = '0; e_ard = '0;
      e_wa = '0; e_wd = '0; e_tnew = '0;
    end else if (!stall) begin
      e_instr = instr_EX; e_pc = PC_EX; e_alu = alu; e_rt = t; e_art = addrRt_EX;
      e_ard = addrRd_EX; e_wa = regWriteAddr_EX; e_wd = wd;
      e_tnew = (Tnew_EX == '0) ? '0 : Tnew_EX - 2'd1;
    end
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (MDU_EN) begin
      old_left = m_left;
      if (!stall && instr_EX == ID_MTHI) m_hi = s;
      if (!stall && instr_EX == ID_MTLO) m_lo = s;
      if (old_left > 0) begin
        m_left--;
        if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (start && !stall) begin
        a = s; b = t; p_wr = 1'b1;
        case (instr_EX)
          ID_MULT:  begin p64 = longint'(a) * longint'(b); m_left = MULT_N; end
          ID_MULTU: begin p64 = 64'(s) * 64'(t);           m_left = MULT_N; end
          ID_DIV:   begin m_left = DIV_N; p_wr = (b != 0);
                          if (p_wr) p64 = {32'(a % b), 32'(a / b)}; end
          default:  begin m_left = DIV_N; p_wr = (t != 0);
                          if (p_wr) p64 = {s % t, s / t}; end
        endcase
        {p_hi, p_lo} = p64;
      end
    end
    @(posedge clk);
    #1;
    if (reset) m_valid = 1'b1;
    if (m_valid) begin
      check("instr_MEM", 64'(instr_MEM), 64'(e_instr));
      check("PC_MEM", 64'(PC_MEM), 64'(e_pc));
      check("aluOut_MEM", 64'(aluOut_MEM), 64'(e_alu));
      check("dataRt_MEM", 64'(dataRt_MEM), 64'(e_rt));
      check("addrRt_MEM", 64'(addrRt_MEM), 64'(e_art));
      check("addrRd_MEM", 64'(addrRd_MEM), 64'(e_ard));
      check("regWriteAddr_MEM", 64'(regWriteAddr_MEM), 64'(e_wa));
      check("regWriteData_MEM", 64'(regWriteData_MEM), 64'(e_wd));
      check("Tnew_MEM", 64'(Tnew_MEM), 64'(e_tnew));
    end
  endtask

  function automatic logic [31:0] rdata();
    logic [31:0] v;
    v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : 32'($urandom());
    if (v == 32'hFFFF_FFFF) v = 32'd5;
    return v;
  endfunction

  task automatic set_op(input logic [WIDTH_INSTR-1:0] id, input logic [31:0] rs_d,
                        input logic [31:0] rt_d);
    instr_EX = id; dataRs_EX = rs_d; dataRt_EX = rt_d;
  endtask

  task automatic idle_ticks(input int n);
    set_op(ID_NOP, 32'd0, 32'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  int busy_cnt;

  initial begin
    reset = 1'b1; stall = 1'b0; clr = 1'b0; regvalid_MEM = 1'b0;
    instr_EX = ID_NOP; PC_EX = '0; dataRs_EX = '0; dataRt_EX = '0; imm_EX = '0;
    addrRs_EX = 5'd1; addrRt_EX = 5'd2; addrRd_EX = '0; regWriteAddr_EX = '0;
    regWriteData_EX = '0; Tnew_EX = '0; regaddr_MEM = '0; regaddr_WB = '0;
    regdata_MEM = '0; regdata_WB = '0;

    tick(); tick();
    reset = 1'b0;
    check("reset_busy", 64'(mdu_busy), 64'(0));
    set_op(ID_MFHI, 32'd0, 32'd0); tick();
    check("reset_mfhi", 64'(regWriteData_MEM), 64'(0));

    // Forwarding priority on rs
    addrRs_EX = 5'd3; addrRt_EX = 5'd7; set_op(ID_ADDU, 32'h99, 32'h5);
    regaddr_MEM = 5'd3; regdata_MEM = 32'h10; regvalid_MEM = 1'b1;
    regaddr_WB = 5'd3; regdata_WB = 32'h20;
    tick(); check("fwd_mem", 64'(aluOut_MEM), 64'h15);
    regvalid_MEM = 1'b0;
    tick(); check("fwd_wb", 64'(aluOut_MEM), 64'h25);
    addrRs_EX = 5'd0; regaddr_MEM = 5'd0; regaddr_WB = 5'd0; dataRs_EX = 32'h40;
    tick(); check("fwd_zero", 64'(aluOut_MEM), 64'h45);
    addrRs_EX = 5'd1; addrRt_EX = 5'd2;

    // mult / multu with busy window length
    set_op(ID_MULT, 32'hFFFF_FFFF, 32'd2); tick();
    set_op(ID_NOP, 32'd0, 32'd0); busy_cnt = 0;
    for (int i = 0; i < 7; i++) begin #1; busy_cnt += int'(mdu_busy); tick(); end
    check("mult_busy_len", 64'(busy_cnt), MDU_EN ? 64'(MULT_N) : 64'd0);
    set_op(ID_MFHI, 0, 0); tick(); check("mult_hi", 64'(regWriteData_MEM), MDU_EN ? 64'hFFFF_FFFF : 64'd0);
    set_op(ID_MFLO, 0, 0); tick(); check("mult_lo", 64'(regWriteData_MEM), MDU_EN ? 64'hFFFF_FFFE : 64'd0);
    set_op(ID_MULTU, 32'hFFFF_FFFF, 32'd2); tick(); idle_ticks(MULT_N);
    set_op(ID_MFHI, 0, 0); tick(); check("multu_hi", 64'(regWriteData_MEM), MDU_EN ? 64'd1 : 64'd0);
    set_op(ID_MFLO, 0, 0); tick(); check("multu_lo", 64'(regWriteData_MEM), MDU_EN ? 64'hFFFF_FFFE : 64'd0);

    // signed divide, then divide by zero keeps HI/LO
    set_op(ID_DIV, 32'hFFFF_FFF9, 32'd2); tick(); idle_ticks(DIV_N);
    set_op(ID_MFLO, 0, 0); tick(); check("div_lo", 64'(regWriteData_MEM), MDU_EN ? 64'hFFFF_FFFD : 64'd0);
    set_op(ID_MFHI, 0, 0); tick(); check("div_hi", 64'(regWriteData_MEM), MDU_EN ? 64'hFFFF_FFFF : 64'd0);
    set_op(ID_DIVU, 32'd7, 32'd0); tick(); idle_ticks(DIV_N);
    set_op(ID_MFHI, 0, 0); tick(); check("divz_hi", 64'(regWriteData_MEM), MDU_EN ? 64'hFFFF_FFFF : 64'd0);
    set_op(ID_MFLO, 0, 0); tick(); check("divz_lo", 64'(regWriteData_MEM), MDU_EN ? 64'hFFFF_FFFD : 64'd0);

    // mthi
    set_op(ID_MTHI, 32'hABCD, 0); tick();
    set_op(ID_MFHI, 0, 0); tick(); check("mthi", 64'(regWriteData_MEM), MDU_EN ? 64'hABCD : 64'd0);

    // stalled mult starts once; clr during busy does not disturb the MDU
    set_op(ID_MULT, 32'd3, 32'd4); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", 64'(instr_MEM), 64'(ID_MFHI));
    end
    stall = 1'b0; tick();
    set_op(ID_NOP, 0, 0); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_bubble", 64'(PC_MEM | 32'(instr_MEM)), 64'd0);
    idle_ticks(MULT_N - 2);
    #1; check("stall_mult_done", 64'(mdu_busy), 64'd0);
    set_op(ID_MFLO, 0, 0); tick(); check("stall_mult_lo", 64'(regWriteData_MEM), MDU_EN ? 64'd12 : 64'd0);

    // reset in the 4th busy cycle of a divide
    set_op(ID_DIV, 32'd100, 32'd7); tick(); idle_ticks(3);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_abort_busy", 64'(mdu_busy), 64'd0);
    set_op(ID_MFHI, 0, 0); tick(); check("rst_abort_hi", 64'(regWriteData_MEM), 64'd0);
    set_op(ID_MFLO, 0, 0); tick(); check("rst_abort_lo", 64'(regWriteData_MEM), 64'd0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      instr_EX        = 6'($urandom_range(0, 39));
      PC_EX           = $urandom();
      dataRs_EX       = rdata();
      dataRt_EX       = rdata();
      imm_EX          = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom()))) : 32'($urandom_range(0, 65535));
      addrRs_EX       = 5'($urandom_range(0, 3));
      addrRt_EX       = 5'($urandom_range(0, 3));
      addrRd_EX       = 5'($urandom());
      regWriteAddr_EX = 5'($urandom());
      regWriteData_EX = $urandom();
      Tnew_EX         = 2'($urandom_range(0, 3));
      regaddr_MEM     = 5'($urandom_range(0, 3));
      regaddr_WB      = 5'($urandom_range(0, 3));
      regdata_MEM     = rdata();
      regdata_WB      = rdata();
      regvalid_MEM    = 1'($urandom_range(0, 1));
      stall           = ($urandom_range(0, 7) == 0);
      clr             = ($urandom_range(0, 9) == 0);
      reset           = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; stall = 1'b0; clr = 1'b0;
    idle_ticks(DIV_N + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
